// File: rtl/idecode_queue.sv
// Instruction decode stage fronted by a DEPTH-entry prefetch queue; decodes the head entry.
// Latency: a word pushed at edge N is decoded on the outputs in the cycle after edge N (no bypass).
// Backpressure: in_ready drops when the queue is full; the head is held until out_ready pops it.
module idecode_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [15:0]       in_ir,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        reg_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        ALU_op,
  output logic [1:0]        shift_op,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        rn_addr,
  output logic [2:0]        rd_addr,
  output logic [2:0]        rm_addr,
  output logic [2:0]        r_addr,
  output logic [2:0]        w_addr,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic [15:0]      head;
  logic [2:0]       sel_addr;

  // Handshake status comes only from registered occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Storage write; no reset needed because occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= in_ir;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the queue and win over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head word; an empty queue decodes as all-zero so stale storage never leaks out.
  assign head = out_valid ? mem[rd_ptr] : 16'h0000;

  assign opcode   = head[15:13];
  assign ALU_op   = head[12:11];
  assign shift_op = head[4:3];
  assign rn_addr  = head[10:8];
  assign rd_addr  = head[7:5];
  assign rm_addr  = head[2:0];
  assign sximm5   = {{(DATA_W-5){head[4]}}, head[4:0]};
  assign sximm8   = {{(DATA_W-8){head[7]}}, head[7:0]};

  // Register-field select for the register file ports; read and write address are the same field.
  always_comb begin
    sel_addr = head[2:0];
    case (reg_sel)
      2'd1:    sel_addr = head[7:5];
      2'd2:    sel_addr = head[10:8];
      default: sel_addr = head[2:0];
    endcase
  end

  assign r_addr = sel_addr;
  assign w_addr = sel_addr;

endmodule

// File: tb/tb_idecode_queue.sv
// Bench for idecode_queue: queue model plus arithmetic decode, checked every cycle,
// with directed scenarios and literal expectations for the key cases.
module tb_idecode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_ir;
  logic [1:0]  reg_sel;

  logic        in_ready, out_valid;
  logic [2:0]  opcode, rn_addr, rd_addr, rm_addr, r_addr, w_addr, count;
  logic [1:0]  ALU_op, shift_op;
  logic [15:0] sximm5, sximm8;

  logic        in_ready32, out_valid32;
  logic [2:0]  opcode32, rn32, rd32, rm32, r32, w32, count32;
  logic [1:0]  alu32, shift32;
  logic [31:0] sximm5_32, sximm8_32;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [15:0] mq[$];
  bit          m_push, m_pop;
  logic [2:0]  exp_sel[4] = '{3'd5, 3'd7, 3'd1, 3'd5};

  always #5 clk = ~clk;

  idecode_queue #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_ir(in_ir), .in_valid(in_valid),
    .in_ready(in_ready), .reg_sel(reg_sel), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op), .sximm5(sximm5), .sximm8(sximm8),
    .rn_addr(rn_addr), .rd_addr(rd_addr), .rm_addr(rm_addr), .r_addr(r_addr), .w_addr(w_addr),
    .count(count)
  );

  idecode_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_ir(in_ir), .in_valid(in_valid),
    .in_ready(in_ready32), .reg_sel(reg_sel), .out_valid(out_valid32), .out_ready(out_ready),
    .opcode(opcode32), .ALU_op(alu32), .shift_op(shift32), .sximm5(sximm5_32), .sximm8(sximm8_32),
    .rn_addr(rn32), .rd_addr(rd32), .rm_addr(rm32), .r_addr(r32), .w_addr(w32),
    .count(count32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value of the low `bits` bits of h, returned as a 32-bit two's complement word.
  function automatic logic [31:0] sext(input logic [15:0] h, input int bits);
    int v;
    v = int'(h) % (1 << bits);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 32'(v);
  endfunction

  function automatic logic [15:0] head_word();
    return {opcode, ALU_op, rn_addr, rd_addr, shift_op, rm_addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference queue: one transfer decision per edge from the sampled inputs.
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
    end else begin
      m_push = in_valid && (mq.size() != DEPTH);
      m_pop  = out_ready && (mq.size() != 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(in_ir);
    end
  end

  // Mid-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    logic [15:0] h;
    logic [31:0] sel;
    if (chk_en) begin
      h = (mq.size() != 0) ? mq[0] : 16'h0000;
      case (reg_sel)
        2'd1:    sel = 32'((h >> 5) % 8);
        2'd2:    sel = 32'((h >> 8) % 8);
        default: sel = 32'(h % 8);
      endcase
      chk("count", count, mq.size());
      chk("in_ready", in_ready, mq.size() != DEPTH);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("opcode", opcode, h / 8192);
      chk("ALU_op", ALU_op, (h / 2048) % 4);
      chk("shift_op", shift_op, (h / 8) % 4);
      chk("rn_addr", rn_addr, (h / 256) % 8);
      chk("rd_addr", rd_addr, (h / 32) % 8);
      chk("rm_addr", rm_addr, h % 8);
      chk("r_addr", r_addr, sel);
      chk("w_addr", w_addr, sel);
      chk("sximm5", sximm5, sext(h, 5) & 32'hFFFF);
      chk("sximm8", sximm8, sext(h, 8) & 32'hFFFF);
      chk("count32", count32, mq.size());
      chk("out_valid32", out_valid32, mq.size() != 0);
      chk("sximm5_32", sximm5_32, sext(h, 5));
      chk("sximm8_32", sximm8_32, sext(h, 8));
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ir = 16'h0; reg_sel = 2'd0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_sximm8", sximm8, 0);

    // Single-word decode of 16'hD1E5.
    in_ir = 16'hD1E5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("d1_out_valid", out_valid, 1);
    chk("d1_opcode", opcode, 3'b110);
    chk("d1_ALU_op", ALU_op, 2'b10);
    chk("d1_shift_op", shift_op, 2'b00);
    chk("d1_rn", rn_addr, 1);
    chk("d1_rd", rd_addr, 7);
    chk("d1_rm", rm_addr, 5);
    chk("d1_sximm5", sximm5, 16'h0005);
    chk("d1_sximm8", sximm8, 16'hFFE5);
    chk("d1_sximm8_32", sximm8_32, 32'hFFFFFFE5);
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i);
      #1;
      chk("d1_r_addr", r_addr, exp_sel[i]);
      chk("d1_w_addr", w_addr, exp_sel[i]);
    end
    reg_sel = 2'd0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("d1_drained", count, 0);

    // Negative imm5.
    in_ir = 16'h6010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("n5_sximm5", sximm5, 16'hFFF0);
    chk("n5_sximm8", sximm8, 16'h0010);
    chk("n5_sximm5_32", sximm5_32, 32'hFFFFFFF0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Fill to full, fifth word refused.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_ir = 16'h1100 + 16'(i);
      step();
    end
    #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);

    // Stall released: full cycle pops only, then concurrent push/pop.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_ir = 16'h2200 + 16'(i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("wrap_count", count, 3);
    chk("wrap_head", head_word(), 16'h2205);
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    #1;
    chk("wrap_drained", count, 0);

    // Flush colliding with push and pop.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_ir = 16'h3300 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("fl_pre_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_ir = 16'hDEAD;
    #1;
    chk("fl_in_ready", in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fl_count", count, 0);
    chk("fl_out_valid", out_valid, 0);
    in_ir = 16'h3344; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("fl_next_head", head_word(), 16'h3344);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-stream.
    in_valid = 1'b1;
    in_ir = 16'h4401; step();
    in_ir = 16'h4402; step();
    in_valid = 1'b0;
    #1;
    chk("rs_pre_count", count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rs_count", count, 0);
    chk("rs_out_valid", out_valid, 0);
    in_valid = 1'b1;
    in_ir = 16'h0000; step();
    in_ir = 16'hA7FF; step();
    in_valid = 1'b0;
    #1;
    chk("rs_first_valid", out_valid, 1);
    chk("rs_first_head", head_word(), 16'h0000);
    out_ready = 1'b1;
    step();
    chk("rs_second_head", head_word(), 16'hA7FF);
    chk("rs_second_opcode", opcode, 3'b101);
    chk("rs_second_sximm8", sximm8, 16'hFFFF);
    step();
    out_ready = 1'b0;
    #1;
    chk("rs_drained", count, 0);

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
